// File: rtl/uart_rx_dma_ctrl.sv
// uart_rx_dma_ctrl
//
// Drains the UART receive FIFO and writes the received bytes into a circular
// buffer of 32-bit words in system memory. Bytes are packed little-endian:
// the first byte goes into lane 0. Each completed word is written with one
// single-beat request/grant transaction.
//
// Optional feature: define UART_RX_DMA_TIMEOUT_EN to flush a partial word
// once cfg_timeout ticks pass with no new data. A flushed word carries a
// partial byte-strobe mask. Without the macro, only full words are written.
//
// Ports:
//   ACLK, ARESETn         clock; asynchronous active-low reset
//   cfg_en                DMA enable (level); a rising edge restarts wr_ptr at 0
//   cfg_base_addr         buffer base address (bits [1:0] ignored)
//   cfg_len_words         buffer length in words (0 behaves as 1)
//   cfg_timeout           idle timeout in ticks, 0 = off (timeout build only)
//   timeout_tick          one-cycle tick, one UART bit time (timeout build only)
//   rx_ready              RX FIFO non-empty
//   rx_data               RX FIFO read data
//   rx_data_read_valid    RX FIFO read data valid
//   rx_data_reg_rd        RX FIFO pop, one-cycle pulse
//   mem_req/mem_gnt       write request / write accepted
//   mem_addr              write address (base + wr_ptr*4)
//   mem_wdata, mem_wstrb  write data and byte strobes
//   wr_ptr                current word index within the buffer
//   buf_wrap              one-cycle pulse after the write that wraps wr_ptr
module uart_rx_dma_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cfg_en,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_len_words,
    input  logic [7:0]            cfg_timeout,
    input  logic                  timeout_tick,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_read_valid,
    output logic                  rx_data_reg_rd,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic [LEN_WIDTH-1:0]  wr_ptr,
    output logic                  buf_wrap
);

    typedef enum logic [1:0] {IDLE, POP, WAIT_DATA, WRITE} state_t;

    state_t                 state;
    logic [1:0]             byte_cnt;
    logic [31:0]            data_q;
    logic [3:0]             strb_q;
    logic [LEN_WIDTH-1:0]   ptr_q;
    logic                   en_q;
    logic [LEN_WIDTH-1:0]   last_idx;
    logic [ADDR_WIDTH-1:0]  base_aligned;

    // Index of the last word in the buffer. A length of 0 behaves as 1.
    always_comb begin
        last_idx = '0;
        if (cfg_len_words != '0)
            last_idx = cfg_len_words - LEN_WIDTH'(1);
    end

    always_comb begin
        base_aligned = {cfg_base_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_addr     = base_aligned + (ADDR_WIDTH'(ptr_q) << 2);
    end

    assign mem_wdata = data_q;
    assign mem_wstrb = strb_q;
    assign wr_ptr    = ptr_q;

`ifdef UART_RX_DMA_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       timeout_hit;

    always_comb
        timeout_hit = (cfg_timeout != 8'd0) && (idle_cnt == cfg_timeout) && (byte_cnt != 2'd0);

    logic unused_base_bits;
    assign unused_base_bits = ^cfg_base_addr[1:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{cfg_timeout, timeout_tick, cfg_base_addr[1:0]};
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            data_q         <= '0;
            strb_q         <= '0;
            ptr_q          <= '0;
            en_q           <= 1'b0;
            rx_data_reg_rd <= 1'b0;
            mem_req        <= 1'b0;
            buf_wrap       <= 1'b0;
`ifdef UART_RX_DMA_TIMEOUT_EN
            idle_cnt       <= '0;
`endif
        end else begin
            rx_data_reg_rd <= 1'b0;
            buf_wrap       <= 1'b0;
            en_q           <= cfg_en;

            case (state)
                IDLE: begin
                    if (cfg_en && rx_ready) begin
                        // A pending pop takes priority over a timeout hit
                        // in the same cycle.
                        state          <= POP;
                        rx_data_reg_rd <= 1'b1;
`ifdef UART_RX_DMA_TIMEOUT_EN
                        idle_cnt       <= '0;
`endif
                    end else if (!cfg_en) begin
                        // Disabled while idle: drop any partial word.
                        byte_cnt <= '0;
                        data_q   <= '0;
                        strb_q   <= '0;
`ifdef UART_RX_DMA_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
`ifdef UART_RX_DMA_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state   <= WRITE;
                        mem_req <= 1'b1;
                    end else if ((byte_cnt != 2'd0) && timeout_tick) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
`endif
                end

                POP: state <= WAIT_DATA;

                WAIT_DATA: begin
                    if (rx_data_read_valid) begin
                        data_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        strb_q[byte_cnt]                <= 1'b1;
                        if (byte_cnt == 2'd3) begin
                            state   <= WRITE;
                            mem_req <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= IDLE;
                        end
                    end
                end

                WRITE: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        byte_cnt <= '0;
                        data_q   <= '0;
                        strb_q   <= '0;
                        state    <= IDLE;
`ifdef UART_RX_DMA_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (ptr_q == last_idx) begin
                            ptr_q    <= '0;
                            buf_wrap <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + LEN_WIDTH'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // An enable rising edge restarts the buffer. This assignment comes
            // last, so it overrides a pointer advance in the same cycle.
            if (cfg_en && !en_q)
                ptr_q <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_dma_ctrl.sv
module tb_uart_rx_dma_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        ACLK;
    logic        ARESETn;
    logic        cfg_en;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_len_words;
    logic [7:0]  cfg_timeout;
    logic        timeout_tick;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_data_read_valid;
    logic        rx_data_reg_rd;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] wr_ptr;
    logic        buf_wrap;

    uart_rx_dma_ctrl #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .cfg_en(cfg_en),
        .cfg_base_addr(cfg_base_addr), .cfg_len_words(cfg_len_words),
        .cfg_timeout(cfg_timeout), .timeout_tick(timeout_tick),
        .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_data_read_valid(rx_data_read_valid), .rx_data_reg_rd(rx_data_reg_rd),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .wr_ptr(wr_ptr),
        .buf_wrap(buf_wrap)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        wrap;
        logic [15:0] ptr;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  fifo_q[$];
    int          tests = 0;
    int          fails = 0;
    int          pop_cnt = 0;
    logic        gnt_block = 1'b0;
    logic        chk_pending = 1'b0;
    logic        exp_wrap;
    logic [15:0] exp_ptr;
    logic        pend = 1'b0;
    logic [7:0]  pend_byte;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FIFO model: read data is valid one cycle after the pop pulse.
    always @(posedge ACLK) begin
        #1;
        rx_data_read_valid = pend;
        if (pend) rx_data = pend_byte;
        pend = 1'b0;
        if (rx_data_reg_rd) begin
            pop_cnt++;
            if (fifo_q.size() != 0) begin
                pend_byte = fifo_q.pop_front();
                pend      = 1'b1;
            end
        end
        rx_ready = (fifo_q.size() != 0);
    end

    // Memory slave: grants whenever a request is up unless stalled.
    always @(posedge ACLK) begin
        #1;
        mem_gnt = mem_req && !gnt_block;
    end

    // Monitor: compares each accepted write against the scoreboard. In the
    // cycle after the accept, it checks the wrap pulse and the pointer.
    always @(negedge ACLK) begin
        exp_t e;
        if (chk_pending) begin
            check("buf_wrap", {31'd0, buf_wrap}, {31'd0, exp_wrap});
            check("wr_ptr_after_write", {16'd0, wr_ptr}, {16'd0, exp_ptr});
            chk_pending = 1'b0;
        end
        if (ARESETn && mem_req && mem_gnt) begin
            if (sb.size() == 0) begin
                check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.data);
                check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
                exp_wrap    = e.wrap;
                exp_ptr     = e.ptr;
                chk_pending = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic w, input logic [15:0] p);
        exp_t e;
        e.addr = a; e.data = d; e.strb = s; e.wrap = w; e.ptr = p;
        sb.push_back(e);
    endtask

    task automatic push4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) fifo_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_sb(input int max);
        int i = 0;
        while ((sb.size() != 0 || chk_pending) && i < max) begin
            cyc(1);
            i++;
        end
        cyc(1);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic wait_req(input int max);
        int i = 0;
        while (!mem_req && i < max) begin
            cyc(1);
            i++;
        end
        check("mem_req_rise", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic reenable(input logic [15:0] len);
        cfg_en = 1'b0;
        cyc(2);
        cfg_len_words = len;
        cfg_en = 1'b1;
        cyc(2);
    endtask

    initial begin
        int base_pops;
        int req_cycles;
        int i;

        ARESETn = 1'b0; cfg_en = 1'b0; cfg_base_addr = BASE | 32'h3;
        cfg_len_words = 16'd4; cfg_timeout = 8'd3; timeout_tick = 1'b0;
        rx_ready = 1'b0; rx_data = 8'h00; rx_data_read_valid = 1'b0; mem_gnt = 1'b0;
        cyc(3);

        // Reset values; the low address bits are ignored.
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_rd", {31'd0, rx_data_reg_rd}, 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_wr_ptr", {16'd0, wr_ptr}, 32'd0);
        check("rst_buf_wrap", {31'd0, buf_wrap}, 32'd0);
        ARESETn = 1'b1;
        cyc(2);

        // Basic word.
        cfg_en = 1'b1;
        cyc(1);
        expect_wr(BASE, 32'h4433_2211, 4'hF, 1'b0, 16'd1);
        push4(32'h4433_2211);
        wait_sb(100);

        // len 2 wraps after the second write.
        reenable(16'd2);
        expect_wr(BASE,       32'h0403_0201, 4'hF, 1'b0, 16'd1);
        expect_wr(BASE + 4,   32'h0807_0605, 4'hF, 1'b1, 16'd0);
        expect_wr(BASE,       32'h0C0B_0A09, 4'hF, 1'b0, 16'd1);
        push4(32'h0403_0201); push4(32'h0807_0605); push4(32'h0C0B_0A09);
        wait_sb(200);
        check("wr_ptr_end_len2", {16'd0, wr_ptr}, 32'd1);

        // Stalled grant: request stays stable and no pops are issued.
        reenable(16'd4);
        gnt_block = 1'b1;
        expect_wr(BASE,     32'hDDCC_BBAA, 4'hF, 1'b0, 16'd1);
        expect_wr(BASE + 4, 32'h0403_0201, 4'hF, 1'b0, 16'd2);
        push4(32'hDDCC_BBAA);
        wait_req(100);
        base_pops = pop_cnt;
        push4(32'h0403_0201);
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            check("stall_req", {31'd0, mem_req}, 32'd1);
            check("stall_addr", mem_addr, BASE);
            check("stall_wdata", mem_wdata, 32'hDDCC_BBAA);
            check("stall_wstrb", {28'd0, mem_wstrb}, 32'hF);
        end
        check("stall_no_pop", pop_cnt - base_pops, 0);
        check("stall_fifo_fill", fifo_q.size(), 4);
        cyc(1);
        gnt_block = 1'b0;
        wait_sb(200);

        // Two bytes followed by silence.
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
        cyc(15);
`ifdef UART_RX_DMA_TIMEOUT_EN
        expect_wr(BASE + 8, 32'h0000_5AA5, 4'h3, 1'b0, 16'd3);
`endif
        req_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            timeout_tick = 1'b1;
            cyc(1);
            timeout_tick = 1'b0;
            cyc(2);
        end
`ifdef UART_RX_DMA_TIMEOUT_EN
        wait_sb(50);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (mem_req) req_cycles++;
        end
        check("no_flush_without_timeout", req_cycles, 0);
        expect_wr(BASE + 8, 32'h0201_5AA5, 4'hF, 1'b0, 16'd3);
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
        wait_sb(100);
`endif

        // Drop enable while the fourth byte is in flight.
        reenable(16'd4);
        fifo_q.push_back(8'h31); fifo_q.push_back(8'h32); fifo_q.push_back(8'h33);
        cyc(20);
        expect_wr(BASE, 32'h3433_3231, 4'hF, 1'b0, 16'd1);
        fifo_q.push_back(8'h34); fifo_q.push_back(8'h35); fifo_q.push_back(8'h36);
        i = 0;
        while (!rx_data_reg_rd && i < 50) begin
            cyc(1);
            i++;
        end
        check("pop_seen", {31'd0, rx_data_reg_rd}, 32'd1);
        cyc(1);
        cfg_en = 1'b0;
        base_pops = pop_cnt;
        wait_sb(50);
        cyc(10);
        check("disabled_no_pop", pop_cnt - base_pops, 0);
        check("wr_ptr_before_reenable", {16'd0, wr_ptr}, 32'd1);
        fifo_q.delete();
        cyc(2);
        cfg_en = 1'b1;
        cyc(1);
        check("wr_ptr_reenable_clear", {16'd0, wr_ptr}, 32'd0);
        cyc(2);

        // Reset during WRITE aborts the write.
        gnt_block = 1'b1;
        push4(32'h9988_7766);
        wait_req(100);
        @(negedge ACLK);
        #1;
        ARESETn = 1'b0;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("arst_wr_ptr", {16'd0, wr_ptr}, 32'd0);
        check("arst_addr", mem_addr, BASE);
        check("arst_rd", {31'd0, rx_data_reg_rd}, 32'd0);
        cyc(2);
        ARESETn = 1'b1;
        gnt_block = 1'b0;
        req_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            if (mem_req) req_cycles++;
        end
        check("no_residual_req", req_cycles, 0);
        check("scoreboard_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_dma_ctrl.md
# uart_rx_dma_ctrl

Drains the UART receive FIFO autonomously and writes received bytes into a circular word buffer in system memory. Sits between `uart_rx` (FIFO pop side) and a single-beat memory write port on the bus fabric. Packs bytes little-endian into 32-bit words, with an optional idle-timeout flush of partial words.

## Interface
Parameters:
- ADDR_WIDTH, 32, memory address width
- LEN_WIDTH, 16, width of buffer length in words

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- cfg_en  in  1  DMA enable (level)
- cfg_base_addr  in  ADDR_WIDTH  buffer base address; bits [1:0] ignored (word aligned)
- cfg_len_words  in  LEN_WIDTH  buffer length in words; 0 is treated as 1
- cfg_timeout  in  8  idle timeout in ticks; 0 disables the flush
- timeout_tick  in  1  single-cycle tick (one UART bit time)
- rx_ready  in  1  RX FIFO non-empty
- rx_data  in  8  FIFO read data
- rx_data_read_valid  in  1  FIFO read data valid
- rx_data_reg_rd  out  1  FIFO pop, single-cycle pulse
- mem_req  out  1  write request
- mem_gnt  in  1  write accepted this cycle
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes
- wr_ptr  out  LEN_WIDTH  current word index within the buffer
- buf_wrap  out  1  single-cycle pulse when wr_ptr wraps to 0

## Operation
- States: IDLE, POP, WAIT_DATA, WRITE.
- IDLE: if cfg_en && rx_ready, go to POP.
- POP: assert rx_data_reg_rd for exactly one cycle, then go to WAIT_DATA.
- WAIT_DATA: on rx_data_read_valid, place rx_data into byte lane byte_cnt and set the matching strobe bit. If byte_cnt == 3, go to WRITE; otherwise increment byte_cnt and return to IDLE. Only one pop is outstanding at any time.
- WRITE: hold mem_req=1 with stable addr, data and strobes until mem_gnt. On gnt:
  - clear the byte lanes, strobes and byte_cnt;
  - set wr_ptr = (wr_ptr == len-1) ? 0 : wr_ptr+1, and pulse buf_wrap on wrap;
  - go to IDLE.
- Address: mem_addr = {cfg_base_addr[ADDR_WIDTH-1:2],2'b00} + (wr_ptr << 2), with modulo-2^ADDR_WIDTH arithmetic.
- Unwritten byte lanes drive 0 in mem_wdata.
- Timeout flush (when compiled in):
  - idle_cnt counts timeout_tick only while state is IDLE, byte_cnt != 0 and rx_ready == 0.
  - idle_cnt clears on any pop or write.
  - When idle_cnt reaches cfg_timeout (with cfg_timeout != 0), go to WRITE with a partial strobe mask (e.g. 4'b0011 for 2 bytes).
  - If rx_ready and the timeout hit occur in the same cycle, POP wins and idle_cnt clears.
- cfg_en deassert:
  - In POP, WAIT_DATA or WRITE: the current operation completes, including the memory write, and then the block returns to IDLE.
  - In IDLE: partial bytes are discarded and byte_cnt and strobes clear.
  - No new pop is issued while cfg_en is low.
- cfg_en rising edge: wr_ptr clears to 0.
- Configuration inputs must be static while cfg_en=1. Behaviour when they change while enabled is undefined.

## Timing
- Reset values: rx_data_reg_rd=0, mem_req=0, mem_addr=cfg base with wr_ptr=0, mem_wdata=0, mem_wstrb=0, wr_ptr=0, buf_wrap=0, state IDLE, byte_cnt=0, idle_cnt=0.
- Reset asserted mid-operation aborts immediately with no completion of any pending write.
- Pop latency: rx_ready high in IDLE gives rx_data_reg_rd high on the next cycle.
- Per byte: minimum 3 cycles (IDLE, POP, WAIT_DATA) when rx_data_read_valid returns one cycle after the pop.
- Write latency: mem_req rises the cycle after the 4th byte is captured.
- mem_req deasserts the cycle after mem_gnt. A gnt seen in the same cycle req rises is legal and completes in 1 cycle.
- mem_gnt while mem_req=0 is ignored.
- buf_wrap is registered: it is asserted the cycle after the gnt that wraps the pointer.

## Configuration
- Macro: `UART_RX_DMA_TIMEOUT_EN`.
- Defined: idle_cnt is present, and partial words are flushed after cfg_timeout ticks as described above.
- Undefined: idle_cnt and the partial-flush path are removed. cfg_timeout and timeout_tick are unused. Only full 4-byte words are written (mem_wstrb is always 4'hF), and partial bytes wait indefinitely until the word is completed.

## Test plan
- Base 0x1000_0000, len 4, enable; FIFO supplies bytes 0x11,0x22,0x33,0x44 -> one write: addr 0x1000_0000, wdata 0x44332211, wstrb 0xF; wr_ptr becomes 1.
- len 2, feed 12 bytes -> writes to 0x...00, 0x...04, 0x...00, with buf_wrap pulsing after the 2nd write; wr_ptr=1 at the end.
- Hold mem_gnt low for 10 cycles during WRITE -> mem_req and addr/data/strobes stay stable, no pop is issued, and the FIFO keeps filling.
- Timeout enabled, cfg_timeout=3, send 2 bytes 0xA5,0x5A then silence -> after the 3rd tick, write wdata 0x00005AA5, wstrb 0x3. Repeat with the macro undefined -> no write occurs.
- Drop cfg_en while in WAIT_DATA with 3 bytes held -> the 4th byte completes the write; no further pops; re-enabling resets wr_ptr to 0.
- Assert ARESETn low during WRITE -> all outputs return to reset values in the same cycle; after release there is no residual req.
